delay_line_arbiter: RTL and testbench

- Shares one fixed-latency delay line (DELAY register stages, N-bit data, common ce) among NREQ requesters.
- Round-robin arbitration selects one requester per cycle and drives the line's data input and clock enable.
- A parallel tag pipeline tracks which requester owns each in-flight word, so each output word is routed back to its originating requester.
- Sits between the requester blocks and the existing delay-line instance; the delay line itself is external to this block.

---
 rtl/delay_line_arbiter.sv | 137 +++++++++++++
 tb/tb_delay_line_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_arbiter.sv
// rtl/delay_line_arbiter.sv - round-robin sharing of one fixed-latency delay line with tag-routed responses
module delay_line_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int N     = 8,
  parameter  int DELAY = 3,
  localparam int CW    = $clog2(DELAY + 1) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*N-1:0]   idata,
  input  logic                hold,
  input  logic                flush,
  output logic [NREQ-1:0]     gnt,
  output logic                dl_ce,
  output logic [N-1:0]        dl_idata,
  input  logic [N-1:0]        dl_odata,
  output logic [NREQ-1:0]     resp_valid,
  output logic [N-1:0]        resp_data,
  output logic [CW-1:0]       inflight
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic          last_vld;
  logic [IW-1:0] last_idx;
  logic          consumed;

  // The line shifts on every unstalled cycle; idle cycles become bubbles.
  assign dl_ce     = ~hold;
  assign resp_data = dl_odata;
  assign inflight  = inflight_q;

  // Round-robin search starting just after the last winner; no grant during reset, stall or flush.
  always_comb begin : arb
    int cand;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt      = '0;
    dl_idata = '0;
    cand     = 0;
    if (!rst && !hold && !flush) begin
      for (int i = 1; i <= NREQ; i++) begin
        cand = (int'(ptr_q) + i) % NREQ;
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'(cand);
        end
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
      dl_idata     = idata[int'(gnt_idx)*N +: N];
    end
  end

  generate
    if (DELAY > 0) begin : g_tag
      logic [DELAY-1:0] vld_q, vld_d;
      logic [IW-1:0]    idx_q [DELAY];
      logic [IW-1:0]    idx_d [DELAY];

      // Tag pipe mirrors the external line: shifts with dl_ce, flush drops every valid.
      always_comb begin
        vld_d = vld_q;
        idx_d = idx_q;
        if (flush) begin
          vld_d = '0;
        end else if (!hold) begin
          vld_d[0] = gnt_any;
          idx_d[0] = gnt_idx;
          for (int i = 1; i < DELAY; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
          end
        end
      end

      // Tag registers; line data itself is not reset, the valids mask it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < DELAY; i++) idx_q[i] <= '0;
        end else begin
          vld_q <= vld_d;
          idx_q <= idx_d;
        end
      end

      assign last_vld = vld_q[DELAY-1];
      assign last_idx = idx_q[DELAY-1];
    end else begin : g_passthru
      // Zero-latency line: the word returns in the cycle it is granted.
      assign last_vld = gnt_any;
      assign last_idx = gnt_idx;
    end
  endgenerate

  // Route the word at the line output back to its owner; a flush hides it.
  always_comb begin
    resp_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      resp_valid[k] = last_vld && (int'(last_idx) == k) && !flush;
    end
  end

  assign consumed = last_vld & ~hold & ~flush;

  // Pointer follows the winner; occupancy counts grants in and responses out.
  always_comb begin
    ptr_d      = gnt_any ? gnt_idx : ptr_q;
    inflight_d = inflight_q;
    if (flush) begin
      inflight_d = '0;
    end else if (gnt_any && !consumed) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!gnt_any && consumed) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  // Pointer resets to the top index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= IW'(NREQ - 1);
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_delay_line_arbiter.sv
// tb/tb_delay_line_arbiter.sv - table-driven scoreboard bench for delay_line_arbiter
module tb_delay_line_arbiter;

  localparam int NREQ  = 4;
  localparam int N     = 8;
  localparam int DELAY = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [31:0]     idata;
  logic            hold, flush;
  logic [3:0]      gnt;
  logic            dl_ce;
  logic [7:0]      dl_idata, dl_odata;
  logic [3:0]      resp_valid;
  logic [7:0]      resp_data;
  logic [2:0]      inflight;

  logic [3:0]      req_z;
  logic [31:0]     idata_z;
  logic            hold_z, flush_z;
  logic [3:0]      gnt_z;
  logic            dl_ce_z;
  logic [7:0]      dl_idata_z, dl_odata_z;
  logic [3:0]      resp_valid_z;
  logic [7:0]      resp_data_z;
  logic [0:0]      inflight_z;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  delay_line_arbiter #(.NREQ(NREQ), .N(N), .DELAY(DELAY)) u_dut (
    .clk(clk), .rst(rst), .req(req), .idata(idata), .hold(hold), .flush(flush),
    .gnt(gnt), .dl_ce(dl_ce), .dl_idata(dl_idata), .dl_odata(dl_odata),
    .resp_valid(resp_valid), .resp_data(resp_data), .inflight(inflight)
  );

  delay_line_arbiter #(.NREQ(NREQ), .N(N), .DELAY(0)) u_dut_z (
    .clk(clk), .rst(rst), .req(req_z), .idata(idata_z), .hold(hold_z), .flush(flush_z),
    .gnt(gnt_z), .dl_ce(dl_ce_z), .dl_idata(dl_idata_z), .dl_odata(dl_odata_z),
    .resp_valid(resp_valid_z), .resp_data(resp_data_z), .inflight(inflight_z)
  );

  // External delay line model: three ce-qualified stages, not reset.
  logic [7:0] dl_pipe [3];
  always @(posedge clk) begin
    if (dl_ce) begin
      dl_pipe[0] <= dl_idata;
      dl_pipe[1] <= dl_pipe[0];
      dl_pipe[2] <= dl_pipe[1];
    end
  end
  assign dl_odata   = dl_pipe[2];
  assign dl_odata_z = dl_idata_z;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         age;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic       rs;
    logic [3:0] r;
    logic       h;
    logic       f;
    logic [7:0] db;
    logic [3:0] eg;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rs, input logic [3:0] r, input logic h, input logic f,
                     input logic [7:0] db, input logic [3:0] eg);
    vec_t v;
    v.rs = rs; v.r = r; v.h = h; v.f = f; v.db = db; v.eg = eg;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle, compare against the model, take the edge, advance the model.
  task automatic apply_vec(input string tag, input logic [3:0] r, input logic h, input logic f,
                           input logic [7:0] db, input logic [3:0] eg);
    logic [3:0] erv;
    logic [7:0] erd;
    logic [7:0] egd;
    int         gi;
    req = r; hold = h; flush = f;
    for (int k = 0; k < 4; k++) idata[k*8 +: 8] = db + 8'(k * 17);
    gi = 0;
    for (int k = 0; k < 4; k++) if (eg[k]) gi = k;
    egd = (eg != 4'b0) ? db + 8'(gi * 17) : 8'h00;
    erv = 4'b0;
    erd = 8'h00;
    if (!f && sb.size() > 0 && sb[0].age == DELAY) begin
      erv = 4'b0001 << sb[0].idx;
      erd = sb[0].data;
    end
    #2;
    chk({tag, " gnt"}, {28'b0, gnt}, {28'b0, eg});
    chk({tag, " dl_idata"}, {24'b0, dl_idata}, {24'b0, egd});
    chk({tag, " dl_ce"}, {31'b0, dl_ce}, {31'b0, ~h});
    chk({tag, " resp_valid"}, {28'b0, resp_valid}, {28'b0, erv});
    if (erv != 4'b0) chk({tag, " resp_data"}, {24'b0, resp_data}, {24'b0, erd});
    chk({tag, " inflight"}, {29'b0, inflight}, 32'(sb.size()));
    @(posedge clk);
    if (f) begin
      sb.delete();
    end else if (!h) begin
      if (erv != 4'b0) void'(sb.pop_front());
      foreach (sb[i]) sb[i].age = sb[i].age + 1;
      if (eg != 4'b0) sb.push_back('{gi, egd, 1});
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; idata = 32'h0; hold = 1'b0; flush = 1'b0;
    req_z = 4'b0; idata_z = 32'h0; hold_z = 1'b0; flush_z = 1'b0;

    // Single request, data A5, three-cycle latency
    add(1, 4'b0001, 0, 0, 8'hA5, 4'b0001);
    for (int i = 0; i < 4; i++) add(0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    // Full contention, then a two-cycle hold mid-stream, then drain
    for (int i = 0; i < 8; i++) add(i == 0, 4'b1111, 0, 0, 8'(8'h20 + i * 4), 4'b0001 << (i % 4));
    add(0, 4'b1111, 1, 0, 8'h60, 4'b0000);
    add(0, 4'b1111, 1, 0, 8'h64, 4'b0000);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 0, 0, 8'(8'h70 + i * 4), 4'b0001 << i);
    for (int i = 0; i < 4; i++) add(0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    // Three words in flight, flush, then a fresh grant
    add(1, 4'b0001, 0, 0, 8'h10, 4'b0001);
    add(0, 4'b0010, 0, 0, 8'h20, 4'b0010);
    add(0, 4'b0100, 0, 0, 8'h30, 4'b0100);
    add(0, 4'b1000, 0, 1, 8'h40, 4'b0000);
    add(0, 4'b1000, 0, 0, 8'h50, 4'b1000);
    for (int i = 0; i < 4; i++) add(0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    // Requester 1 withdraws before being served
    add(1, 4'b0011, 0, 0, 8'h80, 4'b0001);
    add(0, 4'b0001, 0, 0, 8'h90, 4'b0001);
    for (int i = 0; i < 4; i++) add(0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    // Sparse contention with wrap
    add(1, 4'b1010, 0, 0, 8'hB0, 4'b0010);
    add(0, 4'b1010, 0, 0, 8'hB4, 4'b1000);
    add(0, 4'b1010, 0, 0, 8'hB8, 4'b0010);
    add(0, 4'b0001, 0, 0, 8'hBC, 4'b0001);
    for (int i = 0; i < 4; i++) add(0, 4'b0000, 0, 0, 8'h00, 4'b0000);

    // Reset state with requests pending
    #2;
    chk("reset gnt", {28'b0, gnt}, 32'h0);
    chk("reset resp_valid", {28'b0, resp_valid}, 32'h0);
    chk("reset inflight", {29'b0, inflight}, 32'h0);
    chk("reset dl_idata", {24'b0, dl_idata}, 32'h0);
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset();
      apply_vec($sformatf("vec%0d", i), tbl[i].r, tbl[i].h, tbl[i].f, tbl[i].db, tbl[i].eg);
    end

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++) apply_vec($sformatf("pre_rst%0d", i), 4'b1111, 0, 0, 8'(8'hC0 + i * 4), 4'b0001 << i);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst gnt", {28'b0, gnt}, 32'h0);
    chk("async rst resp_valid", {28'b0, resp_valid}, 32'h0);
    chk("async rst inflight", {29'b0, inflight}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    apply_vec("post_rst0", 4'b1111, 0, 0, 8'hD0, 4'b0001);
    for (int i = 0; i < 4; i++) apply_vec($sformatf("post_rst_idle%0d", i), 4'b0000, 0, 0, 8'h00, 4'b0000);

    // Zero-latency build: same-cycle response
    req_z = 4'b0100;
    idata_z = 32'h11_3C_22_33;
    #1;
    chk("z gnt", {28'b0, gnt_z}, 32'h4);
    chk("z resp_valid", {28'b0, resp_valid_z}, 32'h4);
    chk("z resp_data", {24'b0, resp_data_z}, 32'h3C);
    chk("z inflight", {31'b0, inflight_z}, 32'h0);
    hold_z = 1'b1;
    #1;
    chk("z hold gnt", {28'b0, gnt_z}, 32'h0);
    chk("z hold resp_valid", {28'b0, resp_valid_z}, 32'h0);
    chk("z hold dl_ce", {31'b0, dl_ce_z}, 32'h0);
    hold_z = 1'b0;
    @(posedge clk);
    #1;
    chk("z after edge inflight", {31'b0, inflight_z}, 32'h0);
    req_z = 4'b0101;
    #1;
    chk("z rr gnt", {28'b0, gnt_z}, 32'h1);
    chk("z rr resp_data", {24'b0, resp_data_z}, 32'h33);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
